// File: rtl/vga_pkg.sv
// Shared definitions for the VRAM arbiter slice.
// Holds framebuffer geometry, bus widths, the arbiter state encoding and
// the scan-out address increment helper.
package vga_pkg;

  localparam int FB_WORDS = 480000;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 12;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } arb_state_t;

  // Next scan-out address; the last framebuffer word wraps back to 0.
  function automatic logic [ADDR_W-1:0] next_fb_addr(input logic [ADDR_W-1:0] a,
                                                     input int fb_words);
    if (a == ADDR_W'(fb_words - 1)) return '0;
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter.
// Groups the display pixel port, the draw-client write port and the SRAM
// port. The slave modport is the arbiter's view, master is the environment.
//   frame_sync, pix_pop            : display control into the arbiter
//   pix_data, pix_valid, underrun  : display pixel stream out of the arbiter
//   wr_req, wr_addr, wr_data       : draw client write request
//   wr_gnt                         : combinational write acceptance
//   mem_addr/re/we/wdata           : registered SRAM command
//   mem_rdata                      : SRAM read data, RD_LAT after mem_re
interface vram_arbiter_if;
  import vga_pkg::*;

  logic              frame_sync;
  logic              pix_pop;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              underrun;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport slave (
    input  frame_sync, pix_pop, wr_req, wr_addr, wr_data, mem_rdata,
    output pix_data, pix_valid, underrun, wr_gnt,
           mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output frame_sync, pix_pop, wr_req, wr_addr, wr_data, mem_rdata,
    input  pix_data, pix_valid, underrun, wr_gnt,
           mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/pix_fifo.sv
// Pixel prefetch FIFO: synchronous, first-word fall-through, with count.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous empty (frame restart), wins over push/pop
//   i_push, i_data : write an entry (dropped when full and not popping)
//   i_pop          : consume the head (ignored when empty)
//   o_head         : head entry, 0 while empty
//   o_valid        : FIFO non-empty
//   o_count        : number of stored entries
module pix_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 12,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  // Pointers rely on natural wrap, so DEPTH is expected to be a power of two.
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the head is masked to 0 while empty instead.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one SRAM port between display scan-out prefetch and
// a draw client. One access is decided per cycle and registered onto the
// SRAM command the next cycle. Display reads are tracked as credit (FIFO
// count + reads in flight) so the prefetch FIFO can never overflow.
// Ports:
//   MAX10_CLK1_50 : sole clock
//   rst_n         : asynchronous active-low reset (removal synchronised)
//   bus           : vram_arbiter_if.slave (display, write client, SRAM)
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 8,
  parameter int RD_LAT     = 2,
  parameter int FB_WORDS   = vga_pkg::FB_WORDS
) (
  input  logic           MAX10_CLK1_50,
  input  logic           rst_n,
  vram_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = CNT_W + 1;

  logic [1:0]        r_rst_sync;
  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [CR_W-1:0]   r_inflight;
  logic [RD_LAT-1:0] r_ret_sh;
  logic              r_underrun;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [PIX_W-1:0]  r_mem_wdata;

  logic              w_en;
  logic              w_sync;
  logic              w_ret;
  logic              w_rd_issue;
  logic              w_wr_gnt;
  logic [CR_W-1:0]   w_credit;
  logic [CR_W-1:0]   w_inflight_dec;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic              w_fifo_valid;
  logic [PIX_W-1:0]  w_fifo_head;
  logic              w_fifo_push;
  logic              w_fifo_pop;

  // Two-flop release of reset: the arbiter starts deciding once the
  // second stage has seen rst_n high.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_en           = r_rst_sync[1];
  assign w_sync         = w_en && bus.frame_sync;
  assign w_ret          = r_ret_sh[RD_LAT-1];
  assign w_credit       = CR_W'(w_fifo_cnt) + r_inflight;
  assign w_inflight_dec = r_inflight - CR_W'(w_ret);

  // Decision logic. Reads are suppressed in the frame_sync cycle so the
  // restarted scan begins cleanly at address 0; writes may still proceed.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_issue  = 1'b0;
    w_wr_gnt    = 1'b0;
    if (w_en) begin
      if (bus.frame_sync) begin
        w_state_nxt = ST_FLUSH;
        w_wr_gnt    = bus.wr_req;
      end else if (r_state == ST_FLUSH) begin
        w_wr_gnt = bus.wr_req;
        // Leave once the last stale read has drained this cycle.
        if (w_inflight_dec == '0) w_state_nxt = ST_RUN;
      end else begin
        if (w_credit < CR_W'(LOW_WM))          w_rd_issue = 1'b1;
        else if (bus.wr_req)                   w_wr_gnt   = 1'b1;
        else if (w_credit < CR_W'(FIFO_DEPTH)) w_rd_issue = 1'b1;
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_rd_addr   <= '0;
      r_inflight  <= '0;
      r_ret_sh    <= '0;
      r_underrun  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_inflight_dec + CR_W'(w_rd_issue);
      r_mem_re   <= w_rd_issue;
      r_mem_we   <= w_wr_gnt;

      // Return tracker: bit RD_LAT-1 marks the cycle mem_rdata is valid.
      r_ret_sh[0] <= r_mem_re;
      for (int k = 1; k < RD_LAT; k++) r_ret_sh[k] <= r_ret_sh[k-1];

      if (w_rd_issue) begin
        r_mem_addr <= r_rd_addr;
      end else if (w_wr_gnt) begin
        r_mem_addr  <= bus.wr_addr;
        r_mem_wdata <= bus.wr_data;
      end

      if (w_sync)          r_rd_addr <= '0;
      else if (w_rd_issue) r_rd_addr <= next_fb_addr(r_rd_addr, FB_WORDS);

      if (w_sync)                                        r_underrun <= 1'b0;
      else if (w_en && bus.pix_pop && !w_fifo_valid)     r_underrun <= 1'b1;
    end
  end

  // Returning data is kept only in RUN; anything landing during a flush
  // (or in the frame_sync cycle itself) belongs to the previous frame.
  assign w_fifo_push = w_ret && (r_state == ST_RUN) && !w_sync;
  assign w_fifo_pop  = w_en && bus.pix_pop && !bus.frame_sync;

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W),
    .CNT_W (CNT_W)
  ) u_pix_fifo (
    .i_clk   (MAX10_CLK1_50),
    .i_rst_n (rst_n),
    .i_clr   (w_sync),
    .i_push  (w_fifo_push),
    .i_data  (bus.mem_rdata),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_cnt)
  );

  assign bus.pix_data  = w_fifo_head;
  assign bus.pix_valid = w_fifo_valid;
  assign bus.underrun  = r_underrun;
  assign bus.wr_gnt    = w_wr_gnt;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: SRAM model with RD_LAT read latency, pixel
// scoreboard fed at each mem_re and checked at each accepted pop, plus one
// task per scenario. The framebuffer size is shrunk so the address wrap is
// reachable in a short run.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int RD_LAT = 2;
  localparam int TB_FB  = 48;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if bus();

  vram_arbiter #(
    .FIFO_DEPTH (16),
    .LOW_WM     (8),
    .RD_LAT     (RD_LAT),
    .FB_WORDS   (TB_FB)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .rst_n         (rst_n),
    .bus           (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q [$];
  logic [18:0] rd_log [$];
  logic [11:0] exp_px;

  function automatic logic [11:0] pix_of(input logic [18:0] a);
    return a[11:0] ^ 12'hA5C;
  endfunction

  // SRAM model: data for a read appears RD_LAT cycles after mem_re.
  logic [RD_LAT-1:0] m_v = '0;
  logic [18:0]       m_a [RD_LAT];
  always @(posedge clk) begin
    m_v[0] <= bus.mem_re;
    m_a[0] <= bus.mem_addr;
    for (int k = 1; k < RD_LAT; k++) begin
      m_v[k] <= m_v[k-1];
      m_a[k] <= m_a[k-1];
    end
  end
  assign bus.mem_rdata = m_v[RD_LAT-1] ? pix_of(m_a[RD_LAT-1]) : 12'h000;

  // Scoreboard: every read is expected in order unless a frame restart
  // (or reset) cancels it; accepted pops are compared against the head.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.mem_re) begin
        exp_q.push_back(pix_of(bus.mem_addr));
        rd_log.push_back(bus.mem_addr);
      end
      total++;
      if (bus.mem_re && bus.mem_we) begin
        bad++;
        $display("FAIL excl: mem_re=1 and mem_we=1 together, required at most one");
      end
      if (bus.frame_sync) begin
        exp_q.delete();
      end else if (bus.pix_pop && bus.pix_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_pop: popped %h, required no pixel available", bus.pix_data);
        end else begin
          exp_px = exp_q.pop_front();
          if (bus.pix_data !== exp_px) begin
            bad++;
            $display("FAIL sb_pix: got %h, required %h", bus.pix_data, exp_px);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.frame_sync = 1'b0;
    bus.pix_pop    = 1'b0;
    bus.wr_req     = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_log.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 19'h7FFFF;
    bus.wr_data = 12'hFFF;
    bus.pix_pop = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.mem_re !== 1'b0)  begin bad++; $display("FAIL rst_mem_re: got %b want 0", bus.mem_re); end
    total++; if (bus.mem_we !== 1'b0)  begin bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.mem_addr !== '0)  begin bad++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== '0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
    total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid: got %b want 0", bus.pix_valid); end
    total++; if (bus.pix_data !== '0)  begin bad++; $display("FAIL rst_pix_data: got %h want 0", bus.pix_data); end
    total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", bus.underrun); end
    total++; if (bus.wr_gnt !== 1'b0)  begin bad++; $display("FAIL rst_wr_gnt: got %b want 0", bus.wr_gnt); end
    drive_idle();
  endtask

  task automatic test_fill();
    int nreads = 0;
    int first  = -1;
    int rise   = -1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_re) begin
        total++;
        if (bus.mem_addr !== 19'(nreads)) begin
          bad++; $display("FAIL fill_addr: got %0d want %0d", bus.mem_addr, nreads);
        end
        if (first < 0) first = i;
        nreads++;
      end
      if (bus.pix_valid && rise < 0) rise = i;
    end
    total++;
    if (nreads != 16) begin bad++; $display("FAIL fill_count: got %0d reads want 16", nreads); end
    total++;
    if (first < 0 || rise < 0 || (rise - first) != 3) begin
      bad++; $display("FAIL fill_latency: pix_valid rise %0d after first mem_re, want 3", rise - first);
    end
  endtask

  task automatic test_write_full();
    @(posedge clk); #1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 19'h12345;
    bus.wr_data = 12'hF00;
    @(negedge clk);
    total++; if (bus.wr_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt: got %b want 1", bus.wr_gnt); end
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL wr_we: got %b want 1", bus.mem_we); end
    total++; if (bus.mem_re !== 1'b0) begin bad++; $display("FAIL wr_re: got %b want 0", bus.mem_re); end
    total++; if (bus.mem_addr !== 19'h12345) begin bad++; $display("FAIL wr_addr: got %h want 12345", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 12'hF00) begin bad++; $display("FAIL wr_data: got %h want f00", bus.mem_wdata); end
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL idle_we: got %b want 0", bus.mem_we); end
    total++; if (bus.mem_addr !== 19'h12345) begin bad++; $display("FAIL idle_addr_hold: got %h want 12345", bus.mem_addr); end
  endtask

  task automatic test_priority();
    int grants = 0;
    int drops  = 0;
    int waited = 0;
    @(posedge clk); #1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 19'h100;
    bus.wr_data = 12'h0A0;
    bus.pix_pop = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!bus.pix_valid) drops++;
      if (bus.wr_gnt) grants++;
      @(posedge clk); #1;
      if (grants > 0) bus.wr_addr = 19'h100 + 19'(grants);
    end
    bus.pix_pop = 1'b0;
    total++; if (drops != 0) begin bad++; $display("FAIL prio_valid: pix_valid low %0d cycles want 0", drops); end
    total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL prio_underrun: got %b want 0", bus.underrun); end
    total++; if (grants != 9) begin bad++; $display("FAIL prio_grants: got %0d writes want 9", grants); end
    // Popping stopped: the FIFO refills and the pending write gets through.
    while (waited < 40) begin
      @(negedge clk);
      if (bus.wr_gnt) break;
      waited++;
    end
    total++; if (waited >= 40) begin bad++; $display("FAIL prio_final_gnt: no grant in %0d cycles want grant", waited); end
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
  endtask

  task automatic test_wrap();
    int cycles = 0;
    do_reset();
    while (rd_log.size() < TB_FB + 4 && cycles < 400) begin
      @(posedge clk); #1;
      bus.pix_pop = bus.pix_valid;
      cycles++;
    end
    bus.pix_pop = 1'b0;
    total++;
    if (rd_log.size() < TB_FB + 4) begin
      bad++; $display("FAIL wrap_timeout: got %0d reads want %0d", rd_log.size(), TB_FB + 4);
    end else begin
      for (int i = TB_FB - 2; i < TB_FB + 2; i++) begin
        total++;
        if (rd_log[i] !== 19'(i % TB_FB)) begin
          bad++; $display("FAIL wrap_addr: read %0d got %0d want %0d", i, rd_log[i], i % TB_FB);
        end
      end
    end
    total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL wrap_underrun: got %b want 0", bus.underrun); end
  endtask

  task automatic test_flush();
    int seen  = -1;
    int pv_hi = 0;
    logic [18:0] addr = '1;
    int waited = 0;
    do_reset();
    while (waited < 20) begin
      @(negedge clk);
      if (bus.mem_re) break;
      waited++;
    end
    total++; if (waited >= 20) begin bad++; $display("FAIL flush_setup: no read seen want read"); end
    @(posedge clk); #1;
    bus.frame_sync = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_re !== 1'b1) begin bad++; $display("FAIL flush_inflight: mem_re %b in sync cycle want 1", bus.mem_re); end
    @(posedge clk); #1;
    bus.frame_sync = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i <= 4 && bus.pix_valid) pv_hi++;
      if (bus.mem_re && seen < 0) begin seen = i; addr = bus.mem_addr; end
      if (i < 8) begin @(posedge clk); #1; end
    end
    total++; if (pv_hi != 0) begin bad++; $display("FAIL flush_discard: pix_valid high %0d cycles want 0", pv_hi); end
    total++; if (seen != 4) begin bad++; $display("FAIL flush_resume: first read at +%0d want +4", seen); end
    total++; if (addr !== 19'h0) begin bad++; $display("FAIL flush_addr: got %0d want 0", addr); end
  endtask

  task automatic test_underrun();
    int drops = 0;
    @(posedge clk); #1;
    bus.frame_sync = 1'b1;
    @(posedge clk); #1;
    bus.frame_sync = 1'b0;
    bus.pix_pop    = 1'b1;
    @(negedge clk);
    total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL udr_pre: pix_valid %b want 0", bus.pix_valid); end
    @(posedge clk); #1;
    bus.pix_pop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.underrun !== 1'b1) drops++;
    end
    total++; if (drops != 0) begin bad++; $display("FAIL udr_sticky: underrun low %0d cycles want 0", drops); end
    // Pop coincident with frame_sync: ignored, and the sticky flag clears.
    @(posedge clk); #1;
    bus.frame_sync = 1'b1;
    bus.pix_pop    = 1'b1;
    @(posedge clk); #1;
    bus.frame_sync = 1'b0;
    bus.pix_pop    = 1'b0;
    @(negedge clk);
    total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL udr_clear: got %b want 0", bus.underrun); end
    repeat (3) @(negedge clk);
    total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL udr_stay_clear: got %b want 0", bus.underrun); end
  endtask

  task automatic test_reset_mid_write();
    repeat (30) @(posedge clk);
    #1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 19'h5A5A5;
    bus.wr_data = 12'h3C3;
    @(negedge clk);
    total++; if (bus.wr_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", bus.wr_gnt); end
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL mid_we_pre: got %b want 1", bus.mem_we); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL mid_we_async: got %b want 0", bus.mem_we); end
    total++; if (bus.mem_addr !== '0) begin bad++; $display("FAIL mid_addr_async: got %h want 0", bus.mem_addr); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_fill();
    test_write_full();
    test_priority();
    test_wrap();
    test_flush();
    test_underrun();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
